alu_mb_seq: RTL and testbench

Multi-byte operation sequencer placed directly upstream of the 8-bit combinational ALU `alu_8bit`. It accepts a full-width request through a valid/ready handshake and latches the operands. It then feeds the ALU one byte per cycle, LSB first, and chains `cout` back into `cin` for additions. Finally it assembles the full-width result and returns it on a valid/ready response channel.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mb_seq.sv | 132 +++++++++++++
 tb/tb_alu_mb_seq.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU and its multi-byte sequencer.
// The op encoding matches the alu_8bit 'f' input bit for bit.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_OR  = 2'b01,
    OP_AND = 2'b10,
    OP_ADD = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mb_state_e;

endpackage

// File: rtl/alu_mb_seq.sv
// Multi-byte sequencer in front of alu_8bit: latches a full-width request, streams it
// LSB byte first through the ALU (carry chained for ADD), and returns the assembled result.
module alu_mb_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  // Handshakes: a transfer happens on any rising edge where valid & ready are both 1.
  // The producer holds valid and payload stable until that edge; ready never waits on valid.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic                req_cin,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [1:0]          alu_f,
  output logic                alu_cin,
  input  logic [7:0]          alu_out,
  input  logic                alu_cout,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [8*NBYTES-1:0] rsp_result,
  output logic                rsp_cout,
  output logic                rsp_zero,
  output mb_state_e           dbg_state
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  mb_state_e       state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  alu_op_e         op_q, op_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            zero_q, zero_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          a_d      = req_a;
          b_d      = req_b;
          op_d     = alu_op_e'(req_op);
          carry_d  = (alu_op_e'(req_op) == OP_ADD) ? req_cin : 1'b0;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        result_d[8*idx_q +: 8] = alu_out;
        carry_d = (op_q == OP_ADD) ? alu_cout : 1'b0;
        idx_d   = idx_q + 1'b1;
        // Flags are captured with the last byte so they land with the final result.
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = carry_d;
          zero_d  = (result_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NOT;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  // ALU drives are decoded from registers only, leaving the whole period for alu_8bit.
  always_comb begin
    alu_a   = 8'h00;
    alu_b   = 8'h00;
    alu_f   = 2'b00;
    alu_cin = 1'b0;
    if (state_q == RUN) begin
      alu_a   = a_q[8*idx_q +: 8];
      alu_b   = b_q[8*idx_q +: 8];
      alu_f   = op_q;
      alu_cin = carry_q;
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign rsp_valid  = (state_q == DONE);
  assign rsp_result = result_q;
  assign rsp_cout   = cout_q;
  assign rsp_zero   = zero_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Directed bench for alu_mb_seq with a behavioural alu_8bit beside it.
module tb_alu_mb_seq;
  import alu_pkg::*;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_cin;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [1:0]   alu_f;
  logic         alu_cin;
  logic [7:0]   alu_out;
  logic         alu_cout;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_zero;
  mb_state_e    dbg_state;

  int n_checks = 0;
  int n_err    = 0;

  alu_mb_seq #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout),
    .rsp_zero   (rsp_zero),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural alu_8bit
  always_comb begin
    alu_out  = 8'h00;
    alu_cout = 1'b0;
    case (alu_f)
      2'b00: alu_out = ~alu_a;
      2'b01: alu_out = alu_a | alu_b;
      2'b10: alu_out = alu_a & alu_b;
      2'b11: {alu_cout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      default: alu_out = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present a request and wait (bounded) for the accepting edge, then scramble the bus.
  task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
    int k;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_ready_wait", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = $urandom();
    req_b     = $urandom();
    req_op    = 2'($urandom_range(0, 3));
    req_cin   = 1'($urandom_range(0, 1));
  endtask

  task automatic check_run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [3:0] cin_pat);
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk($sformatf("alu_a[%0d]", i), alu_a, a[8*i +: 8]);
      chk($sformatf("alu_b[%0d]", i), alu_b, b[8*i +: 8]);
      chk($sformatf("alu_f[%0d]", i), alu_f, op);
      chk($sformatf("alu_cin[%0d]", i), alu_cin, cin_pat[i]);
      chk($sformatf("rsp_valid_run[%0d]", i), rsp_valid, 1'b0);
    end
  endtask

  task automatic check_done(input logic [W-1:0] res, input logic cout, input logic zero);
    @(negedge clk);
    chk("rsp_valid_done", rsp_valid, 1'b1);
    chk("rsp_result", rsp_result, res);
    chk("rsp_cout", rsp_cout, cout);
    chk("rsp_zero", rsp_zero, zero);
    chk("req_ready_done", req_ready, 1'b0);
    chk("alu_a_done", alu_a, 8'h00);
    chk("alu_f_done", alu_f, 2'b00);
    chk("alu_cin_done", alu_cin, 1'b0);
  endtask

  task automatic release_rsp();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after", rsp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
    chk("state_after", dbg_state, IDLE);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_rsp_cout", rsp_cout, 1'b0);
    chk("rst_rsp_zero", rsp_zero, 1'b0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_cin", alu_cin, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1'b1);

    // rsp_ready outside DONE has no effect
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stray_rsp_ready_state", dbg_state, IDLE);
    chk("stray_rsp_valid", rsp_valid, 1'b0);
    rsp_ready = 1'b0;

    // ADD carry ripple: carry into byte 1 only
    send_req(OP_ADD, 32'h000000FF, 32'h00000001, 1'b0);
    check_run(OP_ADD, 32'h000000FF, 32'h00000001, 4'b0010);
    check_done(32'h00000100, 1'b0, 1'b0);
    release_rsp();

    // ADD full carry
    send_req(OP_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1);
    check_run(OP_ADD, 32'hFFFFFFFF, 32'h00000000, 4'b1111);
    check_done(32'h00000000, 1'b1, 1'b1);
    release_rsp();

    // NOT ignores cin
    send_req(OP_NOT, 32'h12345678, 32'hDEADBEEF, 1'b1);
    check_run(OP_NOT, 32'h12345678, 32'hDEADBEEF, 4'b0000);
    check_done(32'hEDCBA987, 1'b0, 1'b0);
    release_rsp();

    // OR
    send_req(OP_OR, 32'hF0F0AA55, 32'h0FF0FF00, 1'b1);
    check_run(OP_OR, 32'hF0F0AA55, 32'h0FF0FF00, 4'b0000);
    check_done(32'hFFF0FF55, 1'b0, 1'b0);
    release_rsp();

    // AND, then backpressure with a second request pending
    send_req(OP_AND, 32'hF0F0AA55, 32'h0FF0FF00, 1'b0);
    check_run(OP_AND, 32'hF0F0AA55, 32'h0FF0FF00, 4'b0000);
    check_done(32'h00F0AA00, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = OP_ADD;
    req_a     = 32'h01020304;
    req_b     = 32'h10203040;
    req_cin   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_rsp_valid[%0d]", i), rsp_valid, 1'b1);
      chk($sformatf("bp_rsp_result[%0d]", i), rsp_result, 32'h00F0AA00);
      chk($sformatf("bp_rsp_flags[%0d]", i), {rsp_cout, rsp_zero}, 2'b00);
      chk($sformatf("bp_req_ready[%0d]", i), req_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_req_ready", req_ready, 1'b1);
    chk("bp_idle_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_a     = 32'hAAAAAAAA;
    req_b     = 32'h55555555;
    check_run(OP_ADD, 32'h01020304, 32'h10203040, 4'b0001);
    check_done(32'h11223345, 1'b0, 1'b0);
    release_rsp();

    // Reset in the middle of RUN at idx 2
    send_req(OP_ADD, 32'h11223344, 32'h01010101, 1'b0);
    repeat (3) @(negedge clk);
    chk("mid_state_run", dbg_state, RUN);
    chk("mid_alu_a_idx2", alu_a, 8'h22);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_state", dbg_state, IDLE);
    chk("mid_rst_alu", {alu_a, alu_b, alu_f, alu_cin}, 19'h0);
    chk("mid_rst_req_ready", req_ready, 1'b0);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_result", rsp_result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("aborted_no_rsp", seen, 1'b0);
    send_req(OP_ADD, 32'h00000001, 32'h00000001, 1'b0);
    check_run(OP_ADD, 32'h00000001, 32'h00000001, 4'b0000);
    check_done(32'h00000002, 1'b0, 1'b0);
    release_rsp();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
